// File: rtl/sha256_digest_reader.sv
`default_nettype none
// ============================================================================
// Module      : sha256_digest_reader
// Description : Captures a 256-bit SHA-256 digest on the rising edge of the
//               processor's done level and streams it out as 32 bytes over a
//               valid/ready byte interface. It can also compare the digest
//               against an expected value at capture time, and it flags any
//               digest that arrives while the previous one is still streaming.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MSB_FIRST   : 1 -> first byte is hash_in[255:248]; 0 -> first is hash_in[7:0]
// Ports
//   clk         : in  clock, all logic on the rising edge
//   rst         : in  synchronous active-high reset
//   hash_in     : in  256-bit digest, valid while hash_done is high
//   hash_done   : in  processor done level (may stay high indefinitely)
//   exp_digest  : in  256-bit expected digest
//   cmp_en      : in  enables the compare at capture
//   m_data      : out streamed digest byte
//   m_valid     : out m_data valid
//   m_ready     : in  sink accepts the byte
//   m_last      : out marks the 32nd byte
//   match       : out compare result
//   match_valid : out match is meaningful
//   busy        : out streaming in progress
//   overrun     : out sticky; a new digest arrived while busy
// ============================================================================
module sha256_digest_reader #(
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] hash_in,
  input  logic         hash_done,
  input  logic [255:0] exp_digest,
  input  logic         cmp_en,
  output logic [7:0]   m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         match,
  output logic         match_valid,
  output logic         busy,
  output logic         overrun
);

  localparam logic [4:0] c_LAST_IDX = 5'd31;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic         done_prev_q;
  logic [255:0] digest_q, digest_d;
  logic [4:0]   idx_q, idx_d;
  logic         match_q, match_d;
  logic         match_valid_q, match_valid_d;
  logic         overrun_q, overrun_d;

  logic         w_capture;
  logic [4:0]   w_lane;
  logic [7:0]   w_lane_byte;

  // A capture is the rising edge of the done level, so a level held high
  // produces exactly one capture.
  assign w_capture = hash_done && !done_prev_q;

  // Byte lane L occupies digest bits [8L+7:8L]. MSB-first order walks the
  // lanes downward from 31, LSB-first walks them upward from 0.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_lane = c_LAST_IDX - idx_q;
    end else begin : g_lsb_first
      assign w_lane = idx_q;
    end
  endgenerate

  assign w_lane_byte = digest_q[{w_lane, 3'b000} +: 8];

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    digest_d      = digest_q;
    idx_d         = idx_q;
    match_d       = match_q;
    match_valid_d = match_valid_q;
    overrun_d     = overrun_q;
    m_valid       = 1'b0;
    m_data        = 8'h00;
    m_last        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_capture) begin
          digest_d      = hash_in;
          idx_d         = 5'd0;
          state_d       = ST_STREAM;
          match_d       = cmp_en && (hash_in == exp_digest);
          match_valid_d = cmp_en;
        end
      end

      ST_STREAM: begin
        m_valid = 1'b1;
        m_data  = w_lane_byte;
        m_last  = (idx_q == c_LAST_IDX);

        // A digest arriving mid-stream (even on the final transfer) is
        // dropped; only the sticky flag records it.
        if (w_capture) begin
          overrun_d = 1'b1;
        end

        if (m_ready) begin
          if (idx_q == c_LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      done_prev_q   <= 1'b0;
      digest_q      <= '0;
      idx_q         <= 5'd0;
      match_q       <= 1'b0;
      match_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_prev_q   <= hash_done;
      digest_q      <= digest_d;
      idx_q         <= idx_d;
      match_q       <= match_d;
      match_valid_q <= match_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign busy        = (state_q == ST_STREAM);
  assign match       = match_q;
  assign match_valid = match_valid_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire
